// File: rtl/mm_fir_avg.sv
// ---------------------------------------------------------------------------
// mm_fir_avg
//
// Moving-average (boxcar FIR) filter for the multimeter datapath. Consumes
// the 12-bit channel-0 sample stream from spi_adc and produces the average
// of the last N = 2^LOG2_N samples, using a circular buffer plus a running
// sum so that each accepted sample costs one add and one subtract.
//
// Parameters:
//   DATA_W  sample width in bits
//   LOG2_N  log2 of the window length (legal range 1..6)
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   din_i          ADC sample, valid while din_update_i=1
//   din_update_i   one-cycle sample strobe
//   clr_i          synchronous flush request (same effect as reset)
//   dout_o         windowed average (sum / N, truncated)
//   dout_update_o  one-cycle strobe, dout_o has just been updated
//   full_o         1 once N samples have been accepted since the last clear
//   ready_o        0 while the buffer is being zeroed; samples are dropped
//   peak_o         (only with MM_FIR_AVG_PEAK_EN) largest dout_o since clear
//
// Optional feature macro: MM_FIR_AVG_PEAK_EN adds the peak_o output.
// ---------------------------------------------------------------------------
module mm_fir_avg #(
    parameter int DATA_W = 12,
    parameter int LOG2_N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din_i,
    input  logic              din_update_i,
    input  logic              clr_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_update_o,
    output logic              full_o,
    output logic              ready_o
`ifdef MM_FIR_AVG_PEAK_EN
    ,
    output logic [DATA_W-1:0] peak_o
`endif
);

    localparam int N     = 1 << LOG2_N;
    localparam int SUM_W = DATA_W + LOG2_N;

    localparam logic [LOG2_N-1:0] PTR_LAST = '1;
    localparam logic [LOG2_N-1:0] PTR_ONE  = LOG2_N'(1);
    localparam logic [LOG2_N:0]   CNT_ONE  = (LOG2_N + 1)'(1);
    localparam logic [LOG2_N:0]   CNT_FULL = {1'b1, {LOG2_N{1'b0}}};

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   buf_q [N];
    logic [LOG2_N-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LOG2_N:0]     cnt_q, cnt_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_update_q, dout_update_d;
    logic                full_q, full_d;
    logic                ready_q, ready_d;
`ifdef MM_FIR_AVG_PEAK_EN
    logic [DATA_W-1:0]   peak_q, peak_d;
`endif

    logic                buf_we;
    logic [DATA_W-1:0]   buf_wdata;
    logic                accept;
    logic [SUM_W-1:0]    new_sum;
    logic [DATA_W-1:0]   avg;
    logic [LOG2_N-1:0]   unused_frac;

    // The slot at wr_ptr always holds the oldest sample (or a zero written
    // during CLEAR), so the sum can never go negative and never exceed
    // N * max sample; SUM_W bits are always enough.
    assign new_sum = sum_q + {{LOG2_N{1'b0}}, din_i} - {{LOG2_N{1'b0}}, buf_q[wr_ptr_q]};

    // Dividing by N is just dropping the low LOG2_N bits (truncation).
    assign {avg, unused_frac} = new_sum;

    assign accept = (state_q != CLEAR) && din_update_i && !clr_i;

    // Next-state logic. clr_i takes priority over everything and restarts
    // the zeroing pass from slot 0; during CLEAR strobes are simply lost.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        cnt_d         = cnt_q;
        sum_d         = sum_q;
        dout_d        = dout_q;
        dout_update_d = 1'b0;
        full_d        = full_q;
        ready_d       = ready_q;
        buf_we        = 1'b0;
        buf_wdata     = '0;
`ifdef MM_FIR_AVG_PEAK_EN
        peak_d        = peak_q;
`endif

        if (clr_i) begin
            state_d  = CLEAR;
            wr_ptr_d = '0;
            cnt_d    = '0;
            sum_d    = '0;
            dout_d   = '0;
            full_d   = 1'b0;
            ready_d  = 1'b0;
`ifdef MM_FIR_AVG_PEAK_EN
            peak_d   = '0;
`endif
        end else begin
            case (state_q)
                CLEAR: begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    ready_d  = 1'b0;
                    if (wr_ptr_q == PTR_LAST) begin
                        state_d = FILL;
                        ready_d = 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        buf_we        = 1'b1;
                        buf_wdata     = din_i;
                        wr_ptr_d      = wr_ptr_q + PTR_ONE;
                        sum_d         = new_sum;
                        dout_d        = avg;
                        dout_update_d = 1'b1;
`ifdef MM_FIR_AVG_PEAK_EN
                        if (avg > peak_q) begin
                            peak_d = avg;
                        end
`endif
                        // The fill counter only matters until the window
                        // is full; in RUN it just rests at N.
                        if (state_q == FILL) begin
                            cnt_d = cnt_q + CNT_ONE;
                            if (cnt_d == CNT_FULL) begin
                                state_d = RUN;
                                full_d  = 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // FSM and all registered outputs. Reset forces the same state as a
    // clear request, including restarting the zeroing pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= CLEAR;
            wr_ptr_q      <= '0;
            cnt_q         <= '0;
            sum_q         <= '0;
            dout_q        <= '0;
            dout_update_q <= 1'b0;
            full_q        <= 1'b0;
            ready_q       <= 1'b0;
`ifdef MM_FIR_AVG_PEAK_EN
            peak_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            sum_q         <= sum_d;
            dout_q        <= dout_d;
            dout_update_q <= dout_update_d;
            full_q        <= full_d;
            ready_q       <= ready_d;
`ifdef MM_FIR_AVG_PEAK_EN
            peak_q        <= peak_d;
`endif
        end
    end

    // Sample storage has no reset: the CLEAR pass that always follows a
    // reset or flush zeroes every slot before any sample is accepted.
    always_ff @(posedge clk) begin
        if (buf_we && !rst && !clr_i) begin
            buf_q[wr_ptr_q] <= buf_wdata;
        end
    end

    assign dout_o        = dout_q;
    assign dout_update_o = dout_update_q;
    assign full_o        = full_q;
    assign ready_o       = ready_q;
`ifdef MM_FIR_AVG_PEAK_EN
    assign peak_o        = peak_q;
`endif

endmodule

// File: tb/tb_mm_fir_avg.sv
// ---------------------------------------------------------------------------
// tb_mm_fir_avg
//
// Self-checking bench for mm_fir_avg (DATA_W=12, LOG2_N=3). Directed steps
// from the filter's expected behaviour, followed by a randomized section;
// every cycle is compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_mm_fir_avg;

    localparam int DATA_W = 12;
    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] din_i;
    logic              din_update_i;
    logic              clr_i;
    logic [DATA_W-1:0] dout_o;
    logic              dout_update_o;
    logic              full_o;
    logic              ready_o;
`ifdef MM_FIR_AVG_PEAK_EN
    logic [DATA_W-1:0] peak_o;
`endif

    always #5 clk = ~clk;

    mm_fir_avg #(
        .DATA_W(DATA_W),
        .LOG2_N(LOG2_N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din_i        (din_i),
        .din_update_i (din_update_i),
        .clr_i        (clr_i),
        .dout_o       (dout_o),
        .dout_update_o(dout_update_o),
        .full_o       (full_o),
        .ready_o      (ready_o)
`ifdef MM_FIR_AVG_PEAK_EN
        ,
        .peak_o       (peak_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the last N accepted samples since the most recent
    // clear, plus how many clear cycles are still pending.
    int                window[$];
    int                accepted;
    int                clear_left;
    logic [DATA_W-1:0] exp_dout;
    logic              exp_upd;
    logic              exp_full;
    logic              exp_ready;
    logic [DATA_W-1:0] exp_peak;

    task automatic modelEdge(input logic r, input logic c, input logic u,
                             input logic [DATA_W-1:0] d);
        int total;
        if (r || c) begin
            window.delete();
            accepted   = 0;
            clear_left = N;
            exp_dout   = '0;
            exp_upd    = 1'b0;
            exp_full   = 1'b0;
            exp_ready  = 1'b0;
            exp_peak   = '0;
        end else if (clear_left > 0) begin
            clear_left = clear_left - 1;
            exp_upd    = 1'b0;
            exp_ready  = (clear_left == 0);
        end else begin
            exp_upd = u;
            if (u) begin
                window.push_back(int'(d));
                if (window.size() > N) void'(window.pop_front());
                accepted = accepted + 1;
                total = 0;
                foreach (window[i]) total += window[i];
                exp_dout = DATA_W'(total / N);
                exp_full = (accepted >= N);
                if (exp_dout > exp_peak) exp_peak = exp_dout;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs away from the rising edge, advance the
    // model across that edge, then compare just after the edge.
    task automatic applyStimulus(input logic r, input logic c, input logic u,
                                 input logic [DATA_W-1:0] d);
        @(negedge clk);
        rst          = r;
        clr_i        = c;
        din_update_i = u;
        din_i        = d;
        modelEdge(r, c, u, d);
        @(posedge clk);
        #1;
        checkOutput("dout", 32'(dout_o), 32'(exp_dout));
        checkOutput("dout_update", 32'(dout_update_o), 32'(exp_upd));
        checkOutput("full", 32'(full_o), 32'(exp_full));
        checkOutput("ready", 32'(ready_o), 32'(exp_ready));
`ifdef MM_FIR_AVG_PEAK_EN
        checkOutput("peak", 32'(peak_o), 32'(exp_peak));
`endif
    endtask

    initial begin
        rst          = 1'b1;
        clr_i        = 1'b0;
        din_update_i = 1'b0;
        din_i        = '0;

        // Reset, then the 8-cycle zeroing pass
        applyStimulus(1, 0, 0, '0);
        applyStimulus(1, 0, 0, '0);
        checkOutput("reset_dout", 32'(dout_o), 32'h0);
        checkOutput("reset_ready", 32'(ready_o), 32'h0);
        repeat (N - 1) applyStimulus(0, 0, 0, '0);
        checkOutput("ready_before_8", 32'(ready_o), 32'h0);
        applyStimulus(0, 0, 0, '0);
        checkOutput("ready_after_8", 32'(ready_o), 32'h1);

        // Ramp-up with 0x800
        applyStimulus(0, 0, 1, 12'h800);
        checkOutput("ramp_first", 32'(dout_o), 32'h100);
        repeat (N - 1) applyStimulus(0, 0, 1, 12'h800);
        checkOutput("ramp_last", 32'(dout_o), 32'h800);
        checkOutput("ramp_full", 32'(full_o), 32'h1);

        // Oldest-sample subtraction and wrap-around
        applyStimulus(0, 0, 1, 12'h000);
        checkOutput("decay_first", 32'(dout_o), 32'h700);
        repeat (N - 1) applyStimulus(0, 0, 1, 12'h000);
        checkOutput("decay_last", 32'(dout_o), 32'h000);

        // Full-scale back-to-back samples
        repeat (N) applyStimulus(0, 0, 1, 12'hFFF);
        checkOutput("fullscale", 32'(dout_o), 32'hFFF);

        // Clear colliding with a strobe: sample dropped
        repeat (N) applyStimulus(0, 0, 1, 12'h400);
        applyStimulus(0, 1, 1, 12'hFFF);
        checkOutput("clr_dout", 32'(dout_o), 32'h0);
        checkOutput("clr_full", 32'(full_o), 32'h0);
        repeat (N) applyStimulus(0, 0, 0, '0);
        applyStimulus(0, 0, 1, 12'h400);
        checkOutput("after_clr", 32'(dout_o), 32'h080);

        // Strobes during CLEAR are lost; reset in the middle of RUN
        applyStimulus(0, 1, 0, '0);
        repeat (N) applyStimulus(0, 0, 1, 12'h3C5);
        repeat (N + 2) applyStimulus(0, 0, 1, DATA_W'($urandom));
        applyStimulus(1, 0, 1, 12'hABC);
        checkOutput("rst_mid_dout", 32'(dout_o), 32'h0);
        repeat (N) applyStimulus(0, 0, 1, 12'h555);
        checkOutput("rst_ready", 32'(ready_o), 32'h1);

`ifdef MM_FIR_AVG_PEAK_EN
        // Peak holds while the average decays; clear returns it to zero
        repeat (N) applyStimulus(0, 0, 1, 12'h800);
        repeat (N) applyStimulus(0, 0, 1, 12'h000);
        checkOutput("peak_hold", 32'(peak_o), 32'h800);
        applyStimulus(0, 1, 0, '0);
        checkOutput("peak_clear", 32'(peak_o), 32'h0);
        repeat (N) applyStimulus(0, 0, 0, '0);
`endif

        // Randomized traffic with occasional clears and resets
        for (int i = 0; i < 600; i++) begin
            logic r, c, u;
            r = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 49) == 0);
            u = ($urandom_range(0, 2) != 0);
            applyStimulus(r, c, u, DATA_W'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mm_fir_avg.md
Name: mm_fir_avg

Overview:
- Moving-average (boxcar FIR) filter for the multimeter datapath.
- Sits directly downstream of spi_adc: consumes the 12-bit channel-0 sample stream and its one-cycle update strobe.
- Produces the averaged value plus its own update strobe, consumed by ste_led_bar and the display/UART path (switch setting "01: Average with FIR filter").
- Window length is 2^LOG2_N samples, held in a circular buffer with a running sum.

Parameters:
DATA_W, 12, sample width in bits (matches spi_adc data0_o)
LOG2_N, 3, log2 of window length; N = 2^LOG2_N; legal range 1..6

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
din_i  input  DATA_W  ADC sample, valid only while din_update_i=1
din_update_i  input  1  one-cycle sample strobe from spi_adc
clr_i  input  1  synchronous flush request (same effect as reset on the filter state)
dout_o  output  DATA_W  windowed average
dout_update_o  output  1  one-cycle strobe, dout_o updated
full_o  output  1  1 once N samples have been accepted since the last clear
ready_o  output  1  0 while the buffer is being cleared; samples are dropped while 0

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Storage:
  - Register array buf[0..N-1] of DATA_W bits.
  - wr_ptr of LOG2_N bits.
  - fill counter cnt of LOG2_N+1 bits.
  - sum of DATA_W+LOG2_N bits. Cannot overflow by construction; no saturation logic.
- FSM states:
  - CLEAR
    - Entered on rst or clr_i.
    - Writes 0 to buf[wr_ptr], one entry per cycle; wr_ptr increments.
    - After N cycles (wr_ptr wraps to 0), go to FILL.
    - ready_o=0. din_update_i is ignored and the sample is lost.
  - FILL
    - ready_o=1.
    - On each accepted sample, cnt increments.
    - When cnt reaches N, go to RUN and set full_o=1 in the same edge as the N-th sample update.
  - RUN
    - Steady state. full_o stays 1.
- Sample accept (FILL or RUN, din_update_i=1, clr_i=0):
  - sum <= sum + din_i - buf[wr_ptr]
  - buf[wr_ptr] <= din_i
  - wr_ptr <= wr_ptr+1, wrapping modulo N
  - Because buf was zeroed in CLEAR, FILL needs no special subtraction path.
- Output:
  - dout_o <= (sum + din_i - buf[wr_ptr]) >> LOG2_N, truncated, no rounding.
  - Registered in the same edge as the accept.
  - dout_update_o=1 for exactly one cycle, the cycle after din_update_i was sampled high. Latency is 1 clk.
  - During FILL, dout_o is the sum divided by N, not by cnt. The ramp-up is intentional.
- Back-to-back strobes (din_update_i high on consecutive cycles) must each be accepted. Throughput is 1 sample/clk.
- Reset values:
  - dout_o=0, dout_update_o=0, full_o=0, ready_o=0.
  - sum=0, wr_ptr=0, cnt=0, state=CLEAR.
- clr_i:
  - Takes effect at the next edge: state=CLEAR, sum=0, cnt=0, wr_ptr=0, full_o=0, dout_o=0, dout_update_o=0. Then the N-cycle clear runs.
  - clr_i together with din_update_i in the same cycle: clr wins and the sample is dropped.
  - clr_i asserted during CLEAR restarts the clear from wr_ptr=0.
- rst asserted mid-operation (any state): identical to clr_i, and overrides it.

Optional Feature:
- Macro: MM_FIR_AVG_PEAK_EN.
- Defined:
  - Adds output peak_o [DATA_W-1:0] (reset 0).
  - On every dout_update_o, peak_o <= max(peak_o, new dout_o).
  - Cleared to 0 by rst or clr_i. Updates in the same edge as dout_o.
- Undefined:
  - peak_o port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then 8 strobes of din_i=0x800 (DATA_W=12, LOG2_N=3):
  - ready_o rises 8 clk after rst release.
  - dout_o sequence 0x100,0x200,...,0x800, each 1 clk after its strobe.
  - full_o rises with the 8th update.
- Window full of 0x800, then 8 strobes of 0x000:
  - dout_o steps 0x700,0x600,...,0x000, confirming wrap-around and oldest-sample subtraction.
- Values 0xFFF x8 on consecutive cycles:
  - 8 dout_update_o pulses on consecutive cycles.
  - Final dout_o=0xFFF, with no sum overflow.
- Window full of 0x400, then clr_i together with din_update_i (din_i=0xFFF):
  - Sample dropped.
  - dout_o=0, full_o=0, ready_o=0 for 8 clk.
  - Next 0x400 strobe gives dout_o=0x080.
- Strobes during CLEAR, then rst mid-RUN:
  - CLEAR strobes produce no dout_update_o.
  - After rst, all outputs are 0 and the 8-cycle clear repeats.
- Peak (MM_FIR_AVG_PEAK_EN defined), samples 0x800 x8 then 0x000 x8:
  - peak_o holds 0x800 while dout_o decays to 0.
  - clr_i returns peak_o to 0.
